// File: rtl/jk_arb_pkg.sv
// Shared op encodings and the JK next-state helper for the bank arbiter.
package jk_arb_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_TGL  = 2'b11;

  // Widest bank the helper supports; callers zero-extend and truncate.
  localparam int JK_MAX_W = 64;

  // JK update of the masked bits; unmasked bits always hold.
  function automatic logic [JK_MAX_W-1:0] jk_next(
    input logic [JK_MAX_W-1:0] q,
    input logic [1:0]          op,
    input logic [JK_MAX_W-1:0] mask
  );
    case (op)
      OP_CLR:  return q & ~mask;
      OP_SET:  return q | mask;
      OP_TGL:  return q ^ mask;
      default: return q;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant with lock override: one-hot grant plus encoded index.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDW-1:0]   i_ptr,
  input  logic             i_lock_en,
  input  logic [IDW-1:0]   i_lock_id,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IDW-1:0]   o_idx
);

  int   w_cand;
  logic w_found;

  // Scan from the pointer with wrap; a held lock admits only its owner.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_cand  = 0;
    w_found = 1'b0;
    if (i_lock_en) begin
      if (i_req[i_lock_id]) begin
        o_gnt[i_lock_id] = 1'b1;
        o_idx            = i_lock_id;
      end
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        w_cand = (int'(i_ptr) + k) % N_REQ;
        if (!w_found && i_req[w_cand]) begin
          w_found       = 1'b1;
          o_gnt[w_cand] = 1'b1;
          o_idx         = IDW'(w_cand);
        end
      end
    end
  end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Arbitrated masked JK commands into a register bank, one command per cycle.
module jk_bank_arbiter
  import jk_arb_pkg::*;
#(
  parameter int               N_REQ     = 4,
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '1,
  parameter int               IDW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [2*N_REQ-1:0]     req_op,
  input  logic [WIDTH*N_REQ-1:0] req_mask,
  input  logic [N_REQ-1:0]       req_lock,
  output logic [N_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]       q,
  output logic [WIDTH-1:0]       qb,
  output logic                   done,
  output logic [IDW-1:0]         done_id,
  output logic                   busy
);

  logic [N_REQ-1:0] w_gnt;
  logic [IDW-1:0]   w_gidx;
  logic             w_xfer;
  logic [1:0]       w_sel_op;
  logic [WIDTH-1:0] w_sel_mask;

  logic [IDW-1:0]   r_ptr;
  logic             r_locked;
  logic [IDW-1:0]   r_lock_id;

  logic             r_cmd_vld_p0;
  logic [1:0]       r_cmd_op_p0;
  logic [WIDTH-1:0] r_cmd_mask_p0;
  logic [IDW-1:0]   r_cmd_id_p0;

  logic [WIDTH-1:0] r_q;
  logic             r_done;
  logic [IDW-1:0]   r_done_id;

  rr_arbiter #(.N_REQ(N_REQ), .IDW(IDW)) u_arb (
    .i_req     (req_valid),
    .i_ptr     (r_ptr),
    .i_lock_en (r_locked),
    .i_lock_id (r_lock_id),
    .o_gnt     (w_gnt),
    .o_idx     (w_gidx)
  );

  // Grant only asserts on a valid requester, so any ready bit is a transfer.
  assign req_ready  = reset ? '0 : w_gnt;
  assign w_xfer     = |req_ready;
  assign w_sel_op   = req_op[2*int'(w_gidx) +: 2];
  assign w_sel_mask = req_mask[WIDTH*int'(w_gidx) +: WIDTH];

  // Pointer advances past the winner; lock follows the winner's lock bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr     <= '0;
      r_locked  <= 1'b0;
      r_lock_id <= '0;
    end else if (w_xfer) begin
      r_ptr     <= (w_gidx == IDW'(N_REQ - 1)) ? '0 : w_gidx + IDW'(1);
      r_locked  <= req_lock[w_gidx];
      r_lock_id <= w_gidx;
    end
  end

  // Stage p0: command register capture
  always_ff @(posedge clk) begin
    if (reset) r_cmd_vld_p0 <= 1'b0;
    else       r_cmd_vld_p0 <= w_xfer;
  end

  // Command payload; qualified by r_cmd_vld_p0 so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_xfer) begin
      r_cmd_op_p0   <= w_sel_op;
      r_cmd_mask_p0 <= w_sel_mask;
      r_cmd_id_p0   <= w_gidx;
    end
  end

  // Stage p1: apply to bank and report completion
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q       <= RESET_VAL;
      r_done    <= 1'b0;
      r_done_id <= '0;
    end else begin
      r_done <= r_cmd_vld_p0;
      if (r_cmd_vld_p0) begin
        r_q       <= WIDTH'(jk_next(JK_MAX_W'(r_q), r_cmd_op_p0, JK_MAX_W'(r_cmd_mask_p0)));
        r_done_id <= r_cmd_id_p0;
      end
    end
  end

  assign q       = r_q;
  assign qb      = ~r_q;
  assign done    = r_done;
  assign done_id = r_done_id;
  assign busy    = r_cmd_vld_p0 | r_locked;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Scoreboard bench for jk_bank_arbiter with default parameters.
module tb_jk_bank_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req_valid;
  logic [2*N-1:0] req_op;
  logic [W*N-1:0] req_mask;
  logic [N-1:0] req_lock;
  logic [N-1:0] req_ready;
  logic [W-1:0] q, qb;
  logic         done;
  logic [1:0]   done_id;
  logic         busy;

  always #5 clk = ~clk;

  jk_bank_arbiter #(.N_REQ(N), .WIDTH(W), .RESET_VAL(8'hFF)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_mask  (req_mask),
    .req_lock  (req_lock),
    .req_ready (req_ready),
    .q         (q),
    .qb        (qb),
    .done      (done),
    .done_id   (done_id),
    .busy      (busy)
  );

  typedef struct {
    logic [1:0] id;
    logic [7:0] qn;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   edge_cnt = 0;
  int   m_ptr = 0;
  bit   m_locked = 0;
  int   m_lid = 0;
  logic [7:0] m_cq = 8'hFF;
  logic [7:0] m_fq = 8'hFF;

  function automatic logic [7:0] model_apply(logic [7:0] cur, logic [1:0] op, logic [7:0] msk);
    logic [7:0] r;
    r = cur;
    for (int b = 0; b < 8; b++) begin
      if (msk[b]) begin
        case (op)
          2'b01:   r[b] = 1'b0;
          2'b10:   r[b] = 1'b1;
          2'b11:   r[b] = ~cur[b];
          default: r[b] = cur[b];
        endcase
      end
    end
    return r;
  endfunction

  function automatic int model_grant();
    int c;
    if (m_locked) return req_valid[m_lid] ? m_lid : -1;
    for (int k = 0; k < N; k++) begin
      c = (m_ptr + k) % N;
      if (req_valid[c]) return c;
    end
    return -1;
  endfunction

  // One clock: check grant before the edge, outputs 1 time unit after it.
  task automatic step();
    int         g;
    bit         rst_s;
    bit         exp_busy;
    logic [3:0] exp_rdy;
    exp_t       e;
    @(negedge clk);
    rst_s   = reset;
    g       = rst_s ? -1 : model_grant();
    exp_rdy = (g < 0) ? 4'b0000 : (4'b0001 << g);
    n_chk++;
    if (req_ready !== exp_rdy) begin
      n_fail++;
      $display("FAIL req_ready edge %0d: got %b need %b", edge_cnt + 1, req_ready, exp_rdy);
    end
    if (g >= 0) begin
      e.id  = g[1:0];
      e.qn  = model_apply(m_fq, req_op[2*g +: 2], req_mask[8*g +: 8]);
      e.due = edge_cnt + 2;
      m_fq  = e.qn;
      sb.push_back(e);
      m_ptr = (g + 1) % N;
      if (req_lock[g]) begin m_locked = 1; m_lid = g; end
      else m_locked = 0;
    end
    @(posedge clk);
    edge_cnt++;
    #1;
    if (rst_s) begin
      sb.delete();
      m_ptr = 0; m_locked = 0; m_lid = 0; m_cq = 8'hFF; m_fq = 8'hFF;
      n_chk++;
      if (done !== 1'b0 || done_id !== 2'd0) begin
        n_fail++;
        $display("FAIL reset_done edge %0d: got done=%b id=%0d need done=0 id=0", edge_cnt, done, done_id);
      end
    end else if (sb.size() > 0 && sb[0].due == edge_cnt) begin
      e = sb.pop_front();
      m_cq = e.qn;
      n_chk++;
      if (done !== 1'b1 || done_id !== e.id) begin
        n_fail++;
        $display("FAIL done_pulse edge %0d: got done=%b id=%0d need done=1 id=%0d", edge_cnt, done, done_id, e.id);
      end
    end else begin
      n_chk++;
      if (done !== 1'b0) begin
        n_fail++;
        $display("FAIL done_idle edge %0d: got done=%b need 0", edge_cnt, done);
      end
    end
    n_chk++;
    if (q !== m_cq || qb !== ~m_cq) begin
      n_fail++;
      $display("FAIL bank edge %0d: got q=%h qb=%h need q=%h qb=%h", edge_cnt, q, qb, m_cq, ~m_cq);
    end
    exp_busy = m_locked || (sb.size() > 0 && sb[0].due == edge_cnt + 1);
    n_chk++;
    if (busy !== exp_busy) begin
      n_fail++;
      $display("FAIL busy edge %0d: got %b need %b", edge_cnt, busy, exp_busy);
    end
  endtask

  task automatic set_req(int i, bit v, logic [1:0] op, logic [7:0] m, bit lk);
    req_valid[i]     = v;
    req_op[2*i +: 2] = op;
    req_mask[8*i +: 8] = m;
    req_lock[i]      = lk;
  endtask

  task automatic idle_all();
    req_valid = '0;
    req_lock  = '0;
  endtask

  task automatic do_reset();
    idle_all();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 2'b11, 8'hFF, 1'b1);
    step();
    step();
    reset = 1'b0;
    idle_all();
    step();
    step();
  endtask

  task automatic test_single();
    do_reset();
    set_req(0, 1'b1, 2'b01, 8'h0F, 1'b0);
    step();
    idle_all();
    step();
    step();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 2'b11, 8'h01, 1'b0);
    repeat (9) step();
    idle_all();
    step();
    step();
  endtask

  task automatic test_lock();
    do_reset();
    set_req(2, 1'b1, 2'b11, 8'h04, 1'b1);
    step();
    for (int i = 0; i < N; i++) if (i != 2) set_req(i, 1'b1, 2'b10, 8'h01 << i, 1'b0);
    set_req(2, 1'b1, 2'b11, 8'h04, 1'b1);
    step();
    req_valid[2] = 1'b0;
    step();
    set_req(2, 1'b1, 2'b11, 8'h04, 1'b1);
    step();
    set_req(2, 1'b1, 2'b11, 8'h04, 1'b0);
    step();
    set_req(2, 1'b0, 2'b00, 8'h00, 1'b0);
    step();
    step();
    idle_all();
    step();
    step();
  endtask

  task automatic test_reset_inflight();
    do_reset();
    set_req(1, 1'b1, 2'b01, 8'hFF, 1'b0);
    step();
    set_req(1, 1'b1, 2'b10, 8'hF0, 1'b0);
    step();
    idle_all();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    step();
  endtask

  task automatic test_noop();
    do_reset();
    set_req(0, 1'b1, 2'b01, 8'h3C, 1'b0);
    step();
    idle_all();
    set_req(3, 1'b1, 2'b00, 8'hFF, 1'b0);
    step();
    set_req(3, 1'b1, 2'b11, 8'h00, 1'b0);
    step();
    idle_all();
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_mask  = '0;
    req_lock  = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_lock();
    test_reset_inflight();
    test_noop();
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d outstanding commands need 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/jk_bank_arbiter.md
# jk_bank_arbiter

Shared controller for a bank of JK-style storage bits. Up to `N_REQ` requesters issue masked JK commands (hold/clear/set/toggle) over a valid/ready handshake. A round-robin arbiter with optional burst lock picks one command per cycle. A one-stage command register then applies the command to the bank and reports completion. It sits between software-visible control agents and the register bank whose bits behave as JK flip-flops with complementary outputs.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `WIDTH`, 8, bank width in bits
- `RESET_VAL`, all ones, bank value after reset
- `clk` in 1: single clock, rising-edge
- `reset` in 1: synchronous, active-high
- `req_valid` in N_REQ: per-requester command valid
- `req_op` in 2*N_REQ: per-requester {J,K}; requester i at bits [2i+1:2i]
- `req_mask` in WIDTH*N_REQ: per-requester bit select; requester i at [WIDTH*i +: WIDTH]
- `req_lock` in N_REQ: keep grant after this transfer
- `req_ready` out N_REQ: one-hot grant, zero when no grant
- `q` out WIDTH: bank state
- `qb` out WIDTH: always ~q
- `done` out 1: one-cycle pulse, command applied
- `done_id` out clog2(N_REQ): requester of applied command
- `busy` out 1: command in flight or lock held

## Operation
- Ops per masked bit: 00 hold, 01 clear, 10 set, 11 toggle. Unmasked bits always hold.
- Transfer = `req_valid[i] & req_ready[i]` at a rising edge.
- `req_ready` is combinational from `req_valid`, `rr_ptr`, and lock state. It is forced to 0 while `reset` is high.
- Arbitration without lock: grant the first valid index scanning `rr_ptr`, `rr_ptr+1`, … with wrap at `N_REQ`.
- On transfer from i: `rr_ptr` <= (i+1) mod N_REQ.
- Lock: a transfer with `req_lock[i]`=1 sets `lock_id`=i and `locked`=1.
  - While locked, only `req_ready[lock_id]` may assert, and only if `req_valid[lock_id]` is high.
  - Other requesters stall, even if the holder's valid drops.
  - A transfer from the holder with `req_lock`=0 clears the lock.
  - The lock never times out. Requesters must not hold it indefinitely.
- Pipeline: transfer loads `cmd_v`, `cmd_op`, `cmd_mask`, `cmd_id`. The next edge applies the command to `q` and pulses `done` with `done_id`=`cmd_id`.
- A new transfer may load the command register on the same edge the previous command is applied. There are no bubbles and throughput is 1 command/cycle.
- Zero mask or op 00: accepted normally, `done` pulses, `q` unchanged.
- `busy` = `cmd_v | locked`.

## Timing
- Reset (sync, any cycle, including mid-burst):
  - `q`=RESET_VAL, `qb`=~RESET_VAL
  - `cmd_v`=0, `done`=0, `done_id`=0
  - `rr_ptr`=0, `locked`=0, `busy`=0
  - An in-flight command is discarded: no `done`, no bank change.
- Latency: transfer at edge E0 → `q`/`qb`/`done` valid after E1 (2 edges from request presentation).
- `done` is high exactly one cycle per applied command. Back-to-back commands keep `done` high continuously with `done_id` changing each cycle.
- `qb` updates on the same edge as `q` and is never out of step.
- `req_*` inputs of non-granted requesters are ignored. Their commands wait; there is no drop.

## Structure
- Package `jk_arb_pkg`: op localparams `OP_HOLD`=2'b00, `OP_CLR`=2'b01, `OP_SET`=2'b10, `OP_TGL`=2'b11; function `jk_next(q, op, mask)` returning the updated WIDTH vector.
- Sub-module `rr_arbiter`:
  - inputs: request vector, pointer, lock enable, lock id
  - output: one-hot grant and encoded index
- The top holds the command register, pointer/lock state, and bank.

## Test plan
Defaults: N_REQ=4, WIDTH=8, RESET_VAL=8'hFF.
- Reset held 2 cycles with all `req_valid`=1 → `req_ready`=0; after release `q`=FF, `qb`=00, `done`=0, `busy`=0.
- Req0 op 01, mask 0F, single transfer → next edge `q`=F0, `qb`=0F, `done`=1, `done_id`=0; following cycle `done`=0.
- All four requesters valid continuously, op 11, mask 01 → grants in order 0,1,2,3,0,…; `done` held high; `q[0]` toggles every cycle.
- Req2 transfers 3 commands with `req_lock`=1, then one with `req_lock`=0, while req0/req1/req3 stay valid → only `req_ready[2]` for 4 transfers; next grant goes to req3, then req0.
- Req1 op 10, mask F0 accepted from `q`=00, with `reset` asserted on the next edge → `q`=FF, no `done` pulse, `busy`=0.
- Req3 op 00, mask FF, then op 11, mask 00 → two `done` pulses with `done_id`=3; `q` unchanged.
